// File: rtl/demorgan_pkg.sv
// Shared types and constants for the De Morgan truth-table sweep engine.
// Mode encodings, FSM states and the sweep length helper.
package demorgan_pkg;

  localparam logic MODE_NOR_FORM  = 1'b0;
  localparam logic MODE_NAND_FORM = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned vec_count(
    input int unsigned w
  );
    return 32'd1 << (2 * w);
  endfunction

endpackage

// File: rtl/demorgan_lanes.sv
// Bitwise evaluation of both sides of the selected De Morgan identity.
// Purely combinational; the sweep top registers the results.
module demorgan_lanes
  import demorgan_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] lhs,
  output logic [WIDTH-1:0] rhs,
  output logic             match
);

  always_comb begin
    lhs = '0;
    rhs = '0;
    unique case (1'b1)
      (mode == MODE_NOR_FORM): begin
        lhs = ~a & ~b;
        rhs = ~(a | b) ^ mask;
      end
      (mode == MODE_NAND_FORM): begin
        lhs = ~a | ~b;
        rhs = ~(a & b) ^ mask;
      end
      default: ;
    endcase
    match = (lhs == rhs);
  end

endmodule

// File: rtl/demorgan_sweep.sv
// Walks every {A,B} vector, streams both identity sides over valid/ready
// and counts accepted vectors whose sides disagree.
module demorgan_sweep
  import demorgan_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   fault_mask,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [WIDTH-1:0]   out_lhs,
  output logic [WIDTH-1:0]   out_rhs,
  output logic               out_match,
  output logic [2*WIDTH:0]   err_count,
  output logic               done
);

  localparam int IW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  localparam int unsigned NVEC = vec_count(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(NVEC - 1);

  state_t r_state;
  state_t r_nxt;

  logic [IW-1:0]    r_idx;
  logic             r_mode;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_lhs;
  logic [WIDTH-1:0] r_rhs;
  logic             r_match;
  logic [EW-1:0]    r_err;

  logic             w_start_acc;
  logic             w_accept;
  logic             w_last;
  logic             w_adv;
  logic [IW-1:0]    w_nidx;
  logic             w_mode;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_lhs;
  logic [WIDTH-1:0] w_rhs;
  logic             w_match;

  assign w_start_acc = (r_state == IDLE) & start;
  assign w_accept    = (r_state == RUN) & out_ready;
  assign w_last      = (r_idx == LAST);
  assign w_adv       = w_accept & ~w_last;

  // Lanes see the vector about to be loaded so outputs stay registered.
  assign w_nidx = w_start_acc ? '0 : r_idx + IW'(1);
  assign w_mode = w_start_acc ? mode : r_mode;
  assign w_mask = w_start_acc ? fault_mask : r_mask;

  demorgan_lanes #(
    .WIDTH (WIDTH)
  ) u_lanes (
    .a     (w_nidx[IW-1:WIDTH]),
    .b     (w_nidx[WIDTH-1:0]),
    .mode  (w_mode),
    .mask  (w_mask),
    .lhs   (w_lhs),
    .rhs   (w_rhs),
    .match (w_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= r_nxt;
  end

  always_comb begin
    r_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) r_nxt = RUN;
      RUN:     if (w_accept && w_last) r_nxt = DONE;
      DONE:    r_nxt = IDLE;
      default: r_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == RUN) | (r_state == DONE);
    out_valid = (r_state == RUN);
    done      = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_mode  <= 1'b0;
      r_mask  <= '0;
      r_lhs   <= '0;
      r_rhs   <= '0;
      r_match <= 1'b0;
      r_err   <= '0;
    end else begin
      if (w_start_acc) begin
        r_mode <= mode;
        r_mask <= fault_mask;
      end
      if (w_start_acc || w_adv) begin
        r_idx   <= w_nidx;
        r_lhs   <= w_lhs;
        r_rhs   <= w_rhs;
        r_match <= w_match;
      end
      if (w_start_acc)
        r_err <= '0;
      else if (w_accept && !r_match)
        r_err <= r_err + EW'(1);
    end
  end

  assign out_a     = r_idx[IW-1:WIDTH];
  assign out_b     = r_idx[WIDTH-1:0];
  assign out_lhs   = r_lhs;
  assign out_rhs   = r_rhs;
  assign out_match = r_match;
  assign err_count = r_err;

endmodule

// File: tb/tb_demorgan_sweep.sv
// Directed bench for demorgan_sweep at WIDTH=1 and WIDTH=2.
// Covers latency, stalls, async reset, ignored inputs and back-to-back runs.
module tb_demorgan_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       s1, m1, r1;
  logic [0:0] k1;
  logic       bs1, v1, mt1, d1;
  logic [0:0] a1, b1, l1, h1;
  logic [2:0] e1;

  logic       s2, m2, r2;
  logic [1:0] k2;
  logic       bs2, v2, mt2, d2;
  logic [1:0] a2, b2, l2, h2;
  logic [4:0] e2;

  int checks = 0;
  int errors = 0;

  demorgan_sweep #(.WIDTH(1)) u1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s1),
    .mode       (m1),
    .fault_mask (k1),
    .busy       (bs1),
    .out_valid  (v1),
    .out_ready  (r1),
    .out_a      (a1),
    .out_b      (b1),
    .out_lhs    (l1),
    .out_rhs    (h1),
    .out_match  (mt1),
    .err_count  (e1),
    .done       (d1)
  );

  demorgan_sweep #(.WIDTH(2)) u2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s2),
    .mode       (m2),
    .fault_mask (k2),
    .busy       (bs2),
    .out_valid  (v2),
    .out_ready  (r2),
    .out_a      (a2),
    .out_b      (b2),
    .out_lhs    (l2),
    .out_rhs    (h2),
    .out_match  (mt2),
    .err_count  (e2),
    .done       (d2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep1(
    input logic       md,
    input logic       mk,
    input logic [3:0] lt,
    input logic [3:0] rt,
    input int         ee,
    input bit         hold
  );
    int ec;
    ec = 0;
    s1 = 1'b1; m1 = md; k1 = mk; r1 = 1'b1;
    chk("w1_pre_valid", 32'(v1), 0);
    step();
    if (!hold) s1 = 1'b0;
    m1 = ~md; k1 = ~mk;
    for (int k = 0; k < 4; k++) begin
      chk("w1_valid", 32'(v1), 1);
      chk("w1_busy", 32'(bs1), 1);
      chk("w1_idx", 32'({a1, b1}), k);
      chk("w1_lhs", 32'(l1), 32'(lt[k]));
      chk("w1_rhs", 32'(h1), 32'(rt[k]));
      chk("w1_match", 32'(mt1), 32'(lt[k] == rt[k]));
      chk("w1_err", 32'(e1), ec);
      chk("w1_nodone", 32'(d1), 0);
      if (lt[k] != rt[k]) ec++;
      step();
    end
    m1 = md; k1 = mk;
    chk("w1_done", 32'(d1), 1);
    chk("w1_done_valid", 32'(v1), 0);
    chk("w1_done_busy", 32'(bs1), 1);
    chk("w1_final_err", 32'(e1), ee);
    step();
    chk("w1_done_pulse", 32'(d1), 0);
    chk("w1_idle_busy", 32'(bs1), 0);
    chk("w1_hold_err", 32'(e1), ee);
  endtask

  task automatic sweep2(
    input logic       md,
    input logic [1:0] mk,
    input int         stall_at,
    input bit         toggle
  );
    int ec;
    logic [3:0] kv;
    logic [1:0] ea, eb, el, er;
    ec = 0;
    s2 = 1'b1; m2 = md; k2 = mk; r2 = 1'b1;
    chk("w2_pre_valid", 32'(v2), 0);
    step();
    s2 = 1'b0;
    k2 = ~mk;
    for (int k = 0; k < 16; k++) begin
      if (toggle) begin
        s2 = (k % 2 == 0);
        m2 = ~m2;
      end
      kv = 4'(k);
      ea = kv[3:2];
      eb = kv[1:0];
      el = md ? (~ea | ~eb) : (~ea & ~eb);
      er = (md ? ~(ea & eb) : ~(ea | eb)) ^ mk;
      chk("w2_valid", 32'(v2), 1);
      chk("w2_a", 32'(a2), 32'(ea));
      chk("w2_b", 32'(b2), 32'(eb));
      chk("w2_lhs", 32'(l2), 32'(el));
      chk("w2_rhs", 32'(h2), 32'(er));
      chk("w2_match", 32'(mt2), 32'(el == er));
      chk("w2_err", 32'(e2), ec);
      if (k == stall_at) begin
        r2 = 1'b0;
        repeat (5) begin
          step();
          chk("w2_stall_valid", 32'(v2), 1);
          chk("w2_stall_ab", 32'({a2, b2}), 32'(kv));
          chk("w2_stall_lhs", 32'(l2), 32'(el));
          chk("w2_stall_rhs", 32'(h2), 32'(er));
          chk("w2_stall_err", 32'(e2), ec);
        end
        r2 = 1'b1;
      end
      if (el != er) ec++;
      step();
    end
    s2 = 1'b0; m2 = md;
    chk("w2_done", 32'(d2), 1);
    chk("w2_done_valid", 32'(v2), 0);
    chk("w2_final_err", 32'(e2), ec);
    step();
    chk("w2_done_pulse", 32'(d2), 0);
    chk("w2_idle_busy", 32'(bs2), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    s1 = 0; m1 = 0; k1 = '0; r1 = 0;
    s2 = 0; m2 = 0; k2 = '0; r2 = 0;
    step();
    step();
    chk("rst_w1_outs", 32'({bs1, v1, a1, b1, l1, h1, mt1, d1}), 0);
    chk("rst_w1_err", 32'(e1), 0);
    chk("rst_w2_outs", 32'({bs2, v2, a2, b2, l2, h2, mt2, d2}), 0);
    chk("rst_w2_err", 32'(e2), 0);
    rst_n = 1'b1;
    step();

    sweep1(1'b0, 1'b0, 4'b0001, 4'b0001, 0, 1'b0);
    sweep1(1'b1, 1'b1, 4'b0111, 4'b1000, 4, 1'b0);

    sweep2(1'b0, 2'b01, 5, 1'b0);

    s2 = 1'b1; m2 = 1'b0; k2 = 2'b01; r2 = 1'b1;
    step();
    s2 = 1'b0;
    repeat (3) step();
    chk("mid_idx", 32'({a2, b2}), 3);
    chk("mid_err", 32'(e2), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", 32'({bs2, v2, a2, b2, l2, h2, mt2, d2}), 0);
    chk("arst_err", 32'(e2), 0);
    step();
    step();
    chk("arst_nodone", 32'(d2), 0);
    rst_n = 1'b1;
    step();
    chk("arst_idle", 32'({bs2, v2}), 0);

    sweep2(1'b0, 2'b00, -1, 1'b0);
    sweep2(1'b1, 2'b00, -1, 1'b1);

    sweep1(1'b0, 1'b0, 4'b0001, 4'b0001, 0, 1'b1);
    sweep1(1'b1, 1'b0, 4'b0111, 4'b0111, 0, 1'b1);
    s1 = 1'b0;
    step();
    chk("b2b_stop_busy", 32'(bs1), 0);
    chk("b2b_stop_valid", 32'(v1), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/demorgan_sweep.md
Name: demorgan_sweep

Overview:
Sequential, parametrised successor to the 2-input De Morgan gate block. It walks every {A,B} combination of WIDTH-bit operands. For each combination it streams out the two sides of a selected De Morgan identity over a valid/ready handshake. It counts every accepted vector where the two sides differ. It is the self-checking truth-table engine for the gate-level lab datapath, replacing manual stimulus tables.

Parameters:
WIDTH, 1, bit width of operands A and B (1..8); the sweep covers 2^(2*WIDTH) vectors.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous assert, active low
start  in  1  begin sweep; sampled only in IDLE
mode  in  1  identity select: 0 = ~A&~B vs ~(A|B); 1 = ~A|~B vs ~(A&B); latched at start
fault_mask  in  WIDTH  XORed into RHS before compare; latched at start; test hook, tie 0 in normal use
busy  out  1  high from the cycle after start is accepted until DONE exits
out_valid  out  1  current vector is presented
out_ready  in  1  consumer accepts vector when out_valid & out_ready
out_a  out  WIDTH  operand A
out_b  out  WIDTH  operand B
out_lhs  out  WIDTH  ~A&~B (mode 0) or ~A|~B (mode 1), bitwise
out_rhs  out  WIDTH  (~(A|B) or ~(A&B)) ^ fault_mask_latched
out_match  out  1  out_lhs == out_rhs
err_count  out  2*WIDTH+1  accepted vectors with out_match=0; holds after done until next start
done  out  1  one-cycle pulse after the last vector is accepted

Behaviour:
- Reset values: state=IDLE, index=0, all outputs 0 including err_count. Reset mid-sweep aborts immediately. No done pulse is generated. err_count is cleared.
- States:
  - IDLE: start=1 -> RUN. Set index=0, clear err_count, latch mode and fault_mask.
  - RUN: out_valid=1. On out_valid & out_ready: if index is the last value (2^(2*WIDTH)-1) -> DONE; otherwise index+1.
  - DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Vector ordering: {out_a,out_b} = index, so A is the most significant half. The order is 00,01,10,11 for WIDTH=1, matching the established truth-table order.
- Latency:
  - Cycle N: start sampled.
  - Cycle N+1: out_valid=1, vector index 0. All out_* come from registers, not from the combinational path of inputs.
- Stall: while out_valid & ~out_ready, out_a/out_b/out_lhs/out_rhs/out_match hold stable and err_count does not change.
- Counting: err_count increments by 1 in the cycle a mismatched vector is accepted. It never wraps; its width holds 2^(2*WIDTH).
- Other out_* in IDLE/DONE: out_valid=0; other out_* hold their last values (don't-care to consumers).
- Ignored inputs: start while busy. Changes on mode or fault_mask after latch.
- busy and out_valid: busy=1 in RUN and DONE. out_valid is never high in DONE.
- Back-to-back: start asserted in the DONE cycle is ignored. start sampled on the following IDLE cycle relaunches.
- Identity with fault_mask=0: out_match=1 for every vector in both modes, so err_count ends at 0.

Decomposition:
- Package demorgan_pkg:
  - mode encodings MODE_NOR_FORM=0, MODE_NAND_FORM=1
  - state enum IDLE/RUN/DONE
  - localparam function for vector count 2^(2*WIDTH)
- Sub-module demorgan_lanes (combinational, WIDTH-wide): takes a, b, mode, mask; produces lhs, rhs, match. The top registers its outputs.

Test Plan:
- WIDTH=1, mode=0, mask=0, out_ready=1, pulse start -> out_valid rises 1 cycle later. Exactly 4 vectors (a,b)=00,01,10,11 with lhs=rhs=1,0,0,0. done pulses once 1 cycle after the 4th accept. err_count=0.
- WIDTH=1, mode=1, mask=1 -> lhs=1,1,1,0 and rhs=0,0,0,1. All 4 vectors mismatch. err_count=4 at done.
- WIDTH=2, mode=0, mask=2'b01, out_ready held 0 for 5 cycles mid-sweep -> outputs frozen during stall. 16 vectors total. err_count=16, since the mask breaks every vector.
- rst_n pulled low after the 3rd accept of a WIDTH=2 sweep -> all outputs 0 immediately and asynchronously. No done pulse. A new start restarts at index 0 with err_count=0.
- start and mode toggled repeatedly during RUN -> no restart. Mode stays at its latched value. Vector count is unchanged.
- start held high continuously -> sweeps run back-to-back, with one IDLE cycle between each done and the next busy.
